// File: rtl/dcache_line_mover.sv
// Line-fill / write-back engine: dirty victim out as one AXI INCR write burst, refill in as one AXI INCR read burst.
// Optional build macro DCACHE_RESP_ERR_EN enables the sticky response-error flag on err_o.
module dcache_line_mover #(
  parameter  int unsigned DATA_W        = 32,
  parameter  int unsigned WORD_OFF_SIZE = 4,
  parameter  int unsigned ADDR_W        = 32,
  localparam int unsigned LINE_W        = DATA_W << WORD_OFF_SIZE
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wb_i,
  input  logic [ADDR_W-1:0] req_wb_addr_i,
  input  logic [LINE_W-1:0] req_wb_data_i,
  input  logic [ADDR_W-1:0] req_rf_addr_i,
  output logic              done_o,
  output logic [LINE_W-1:0] rf_data_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic [7:0]        awlen_o,
  output logic [2:0]        awsize_o,
  output logic [1:0]        awburst_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic              wlast_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic [7:0]        arlen_o,
  output logic [2:0]        arsize_o,
  output logic [1:0]        arburst_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rlast_i,
  input  logic              rvalid_i,
  output logic              rready_o
);

  localparam int unsigned WORDS  = 1 << WORD_OFF_SIZE;
  localparam int unsigned CNT_W  = WORD_OFF_SIZE;
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8) + WORD_OFF_SIZE;
  localparam int unsigned LADR_W = ADDR_W - OFF_W;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WORDS - 1);
  localparam logic [7:0]       BURST_LEN  = 8'(WORDS - 1);
  localparam logic [2:0]       BURST_SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [1:0]       BURST_INCR = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_e;

  state_e                        state_q;
  logic [CNT_W-1:0]              cnt_q;
  logic                          done_q;
  logic [LADR_W-1:0]             wb_addr_q;
  logic [LADR_W-1:0]             rf_addr_q;
  logic [WORDS-1:0][DATA_W-1:0]  wb_data_q;
  logic [WORDS-1:0][DATA_W-1:0]  rf_data_q;

  // Main sequencer: optional write-back burst, then refill burst, then done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      rf_data_q <= '0;
      wb_addr_q <= '0;
      rf_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          wb_addr_q <= req_wb_addr_i[ADDR_W-1:OFF_W];
          rf_addr_q <= req_rf_addr_i[ADDR_W-1:OFF_W];
          wb_data_q <= req_wb_data_i;
          state_q   <= req_wb_i ? S_AW : S_AR;
        end
        S_AW: if (awready_i) begin
          cnt_q   <= '0;
          state_q <= S_W;
        end
        S_W: if (wready_i) begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= S_B;
        end
        S_B: if (bvalid_i) state_q <= S_AR;
        S_AR: if (arready_i) begin
          cnt_q   <= '0;
          state_q <= S_R;
        end
        // Extra beats beyond the line overwrite the last word.
        S_R: if (rvalid_i) begin
          rf_data_q[cnt_q] <= rdata_i;
          if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CNT_W'(1);
          if (rlast_i) state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = resetn && (state_q == S_IDLE);
  assign done_o      = done_q;
  assign rf_data_o   = rf_data_q;

  assign awvalid_o = (state_q == S_AW);
  assign awaddr_o  = {wb_addr_q, OFF_W'(0)};
  assign awlen_o   = BURST_LEN;
  assign awsize_o  = BURST_SIZE;
  assign awburst_o = BURST_INCR;

  assign wvalid_o = (state_q == S_W);
  assign wdata_o  = wb_data_q[cnt_q];
  assign wstrb_o  = '1;
  assign wlast_o  = (state_q == S_W) && (cnt_q == CNT_LAST);

  assign bready_o = (state_q == S_B);

  assign arvalid_o = (state_q == S_AR);
  assign araddr_o  = {rf_addr_q, OFF_W'(0)};
  assign arlen_o   = BURST_LEN;
  assign arsize_o  = BURST_SIZE;
  assign arburst_o = BURST_INCR;

  assign rready_o = (state_q == S_R);

`ifdef DCACHE_RESP_ERR_EN
  logic err_q;
  logic unused_bits;

  // Sticky: any non-OKAY response on a B or R handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if ((state_q == S_B && bvalid_i && bresp_i != 2'b00) ||
                 (state_q == S_R && rvalid_i && rresp_i != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o       = err_q;
  assign unused_bits = ^{req_wb_addr_i[OFF_W-1:0], req_rf_addr_i[OFF_W-1:0]};
`else
  logic unused_bits;

  assign err_o       = 1'b0;
  assign unused_bits = ^{req_wb_addr_i[OFF_W-1:0], req_rf_addr_i[OFF_W-1:0], bresp_i, rresp_i};
`endif

endmodule

// File: tb/tb_dcache_line_mover.sv
// Directed bench for dcache_line_mover with a reactive AXI slave and queue scoreboards.
module tb_dcache_line_mover;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 512;
`ifdef DCACHE_RESP_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0, req_ready, req_wb = 1'b0;
  logic [ADDR_W-1:0] req_wb_addr = '0, req_rf_addr = '0;
  logic [LINE_W-1:0] req_wb_data = '0, rf_data;
  logic              done, err;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0]        awlen, arlen;
  logic [2:0]        awsize, arsize;
  logic [1:0]        awburst, arburst;
  logic              awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
  logic              rvalid = 1'b0, rlast = 1'b0;
  logic [1:0]        bresp = 2'b00, rresp = 2'b00;
  logic [DATA_W-1:0] rdata = '0;

  dcache_line_mover dut (
    .clk(clk), .resetn(resetn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wb_i(req_wb),
    .req_wb_addr_i(req_wb_addr), .req_wb_data_i(req_wb_data), .req_rf_addr_i(req_rf_addr),
    .done_o(done), .rf_data_o(rf_data), .err_o(err),
    .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
    .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .arvalid_o(arvalid), .arready_i(arready),
    .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards filled when a request is driven, drained when the DUT produces the item.
  logic [LINE_W-1:0] line_q[$];
  logic [ADDR_W-1:0] awaddr_q[$];
  logic [ADDR_W-1:0] araddr_q[$];
  logic [DATA_W-1:0] wbeat_q[$];

  // Slave knobs (set by the stimulus) and slave state.
  int          aw_delay = 0;
  bit          stall_en = 1'b0;
  int          err_beat = -1;
  logic [31:0] rbase = '0;
  int          aw_wait = 0, b_exp = 0;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, r_beat = 0, done_cnt = 0;
  int          ar_cyc = 0, r_cyc = 0, done_cyc = 0, acc_cyc = 0;
  bit          aw_fire, w_fire, b_fire, ar_fire, r_fire, r_active, b_pending, w_last_fire;
  logic        prev_awvalid, prev_wvalid, prev_arvalid, prev_rready;
  logic [ADDR_W-1:0] prev_awaddr, prev_araddr;
  logic [DATA_W-1:0] prev_wdata, exp_w;
  logic        prev_wlast;

  task automatic slave_clear();
    {aw_fire, w_fire, b_fire, ar_fire, r_fire, r_active, b_pending, w_last_fire} = '0;
    {prev_awvalid, prev_wvalid, prev_arvalid, prev_rready, prev_wlast} = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; r_beat = 0;
    line_q.delete(); awaddr_q.delete(); araddr_q.delete(); wbeat_q.delete();
  endtask

  initial slave_clear();

  // Reactive slave: retire last edge's handshakes, check holds, then decide this edge's.
  always @(negedge clk) begin
    if (aw_fire) aw_hs++;
    if (w_fire) begin
      w_hs++;
      if (w_last_fire) b_pending = 1'b1;
    end
    if (b_fire) begin b_hs++; bvalid = 1'b0; end
    if (ar_fire) begin r_active = 1'b1; r_beat = 0; end
    if (r_fire) begin
      if (rlast) r_active = 1'b0;
      r_beat++;
    end
    {aw_fire, w_fire, b_fire, ar_fire, r_fire, w_last_fire} = '0;

    if (prev_awvalid && !awready) check("aw_hold", {awvalid, awaddr}, {1'b1, prev_awaddr});
    if (prev_wvalid && !wready)   check("w_hold", {wvalid, wdata, wlast}, {1'b1, prev_wdata, prev_wlast});
    if (prev_arvalid && !arready) check("ar_hold", {arvalid, araddr}, {1'b1, prev_araddr});
    if (arvalid && !prev_arvalid) ar_cyc = cyc;
    if (rready && !prev_rready)   r_cyc = cyc;

    awready = 1'b0;
    if (awvalid) begin
      if (aw_wait > 0) aw_wait--;
      else begin
        awready = 1'b1; aw_fire = 1'b1;
        check("aw_underflow", 512'(awaddr_q.size() > 0), 512'(1));
        if (awaddr_q.size() > 0) check("awaddr", awaddr, awaddr_q.pop_front());
        check("aw_attr", {awlen, awsize, awburst}, {8'd15, 3'd2, 2'b01});
      end
    end

    wready = 1'b0;
    if (wvalid) begin
      wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wready) begin
        w_fire = 1'b1;
        w_last_fire = wlast;
        check("w_underflow", 512'(wbeat_q.size() > 0), 512'(1));
        if (wbeat_q.size() > 0) begin
          exp_w = wbeat_q.pop_front();
          check("wbeat", {wdata, wstrb, wlast}, {exp_w, 4'hF, wbeat_q.size() == 0});
        end
      end
    end

    if (b_pending) begin bvalid = 1'b1; bresp = 2'b00; b_pending = 1'b0; end
    if (bvalid && bready) b_fire = 1'b1;

    arready = 1'b0;
    if (arvalid) begin
      arready = 1'b1; ar_fire = 1'b1;
      check("ar_after_b", 512'(b_hs), 512'(b_exp));
      check("ar_underflow", 512'(araddr_q.size() > 0), 512'(1));
      if (araddr_q.size() > 0) check("araddr", araddr, araddr_q.pop_front());
      check("ar_attr", {arlen, arsize, arburst}, {8'd15, 3'd2, 2'b01});
    end

    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    if (r_active) begin
      rvalid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      rdata  = rbase + 32'(r_beat);
      rlast  = (r_beat == 15);
      rresp  = (r_beat == err_beat) ? 2'b10 : 2'b00;
      if (rvalid && rready) r_fire = 1'b1;
    end

    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_underflow", 512'(line_q.size() > 0), 512'(1));
      if (line_q.size() > 0) check("rf_data", rf_data, line_q.pop_front());
    end

    prev_awvalid = awvalid; prev_awaddr = awaddr;
    prev_wvalid = wvalid; prev_wdata = wdata; prev_wlast = wlast;
    prev_arvalid = arvalid; prev_araddr = araddr;
    prev_rready = rready;
  end

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] base);
    logic [LINE_W-1:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic issue(input bit wb, input logic [31:0] wba, input logic [31:0] vbase,
                       input logic [31:0] rfa, input logic [31:0] base, input bit hold);
    int n;
    line_q.push_back(mk_line(base));
    araddr_q.push_back({rfa[31:6], 6'b0});
    if (wb) begin
      awaddr_q.push_back({wba[31:6], 6'b0});
      for (int i = 0; i < 16; i++) wbeat_q.push_back(vbase + 32'(i));
    end
    rbase = base;
    b_exp = b_hs + (wb ? 1 : 0);
    aw_wait = aw_delay;
    @(negedge clk);
    req_wb = wb; req_wb_addr = wba; req_wb_data = mk_line(vbase); req_rf_addr = rfa;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check("accept_timeout", 512'(n < 100), 512'(1));
    acc_cyc = cyc;
    if (!hold) begin @(negedge clk); req_valid = 1'b0; end
  endtask

  task automatic wait_done(input int budget);
    int start, n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin @(negedge clk); n++; end
    check("done_timeout", 512'(done_cnt - start), 512'(1));
    @(negedge clk);
    check("done_pulse", 512'(done), 512'(0));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : stim
    int aw0, w0, b0, d0, acc, n;
    repeat (3) @(negedge clk);
    check("rst_outs", {req_ready, awvalid, wvalid, bready, arvalid, rready, done, err}, 8'b0);
    check("rst_rf_data", rf_data, '0);
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 512'(req_ready), 512'(1));

    // 1: clean miss, all ready, exact latency.
    aw0 = aw_hs;
    issue(1'b0, 32'h0, 32'h0, 32'h1000_0044, 32'hA000_0000, 1'b0);
    wait_done(100);
    check("clean_ar_lat", 512'(ar_cyc - acc_cyc), 512'(1));
    check("clean_r_lat", 512'(r_cyc - acc_cyc), 512'(2));
    check("clean_done_lat", 512'(done_cyc - acc_cyc), 512'(19));
    check("clean_no_aw", 512'(aw_hs - aw0), 512'(0));
    repeat (3) @(negedge clk);
    check("rf_data_held", rf_data, mk_line(32'hA000_0000));

    // 2: dirty miss, victim word i = i.
    w0 = w_hs; b0 = b_hs;
    issue(1'b1, 32'h2000_0080, 32'h0, 32'h3000_0100, 32'hB000_0000, 1'b0);
    wait_done(200);
    check("dirty_w_beats", 512'(w_hs - w0), 512'(16));
    check("dirty_b_hs", 512'(b_hs - b0), 512'(1));

    // 3: random W/R stalls and delayed awready.
    stall_en = 1'b1; aw_delay = 5;
    w0 = w_hs;
    issue(1'b1, 32'h2000_10C4, 32'h5555_0000, 32'h4000_0200, 32'hC000_0000, 1'b0);
    wait_done(600);
    check("stall_w_beats", 512'(w_hs - w0), 512'(16));
    stall_en = 1'b0; aw_delay = 0;

    // 4: req_valid held across the whole transaction.
    d0 = done_cnt;
    issue(1'b0, 32'h0, 32'h0, 32'h5000_0000, 32'hD000_0000, 1'b1);
    acc = 1; n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (done) begin req_valid = 1'b0; break; end
      if (req_ready) acc++;
      n++;
    end
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("hold_accepts", 512'(acc), 512'(1));
    check("hold_dones", 512'(done_cnt - d0), 512'(1));

    // 5: reset in the middle of the write burst, then a fresh clean miss.
    w0 = w_hs;
    issue(1'b1, 32'h2000_0200, 32'h7700_0000, 32'h6100_0000, 32'h1234_0000, 1'b0);
    n = 0;
    while ((w_hs - w0) < 7 && n < 200) begin @(negedge clk); n++; end
    resetn = 1'b0;
    @(posedge clk);
    #1 slave_clear();
    @(negedge clk);
    check("midrst_outs", {req_ready, awvalid, wvalid, bready, arvalid, rready, done}, 7'b0);
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_ready", 512'(req_ready), 512'(1));
    issue(1'b0, 32'h0, 32'h0, 32'h6000_0040, 32'hE000_0000, 1'b0);
    wait_done(100);
    check("post_rst_done_lat", 512'(done_cyc - acc_cyc), 512'(19));

    // 6: SLVERR on read beat 3.
    err_beat = 3;
    issue(1'b0, 32'h0, 32'h0, 32'h7000_0000, 32'hF000_0000, 1'b0);
    wait_done(100);
    err_beat = -1;
    check("err_flag", 512'(err), 512'(ERR_EXP));
    repeat (5) @(negedge clk);
    check("err_sticky", 512'(err), 512'(ERR_EXP));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
